// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch FSM feeding a fetch-to-decode bus, with redirect handling.
// Optional performance counters are included when FETCH_PERF_COUNTERS_EN is defined.
module fetch_unit #(
    parameter int              ADDR_W   = 32,
    parameter int              INSN_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [INSN_W-1:0] imem_rsp_data,
    input  logic              f2d_busy,
    output logic              f2d_send,
    output logic [ADDR_W-1:0] f2d_pc,
    output logic [INSN_W-1:0] f2d_insn,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall
`endif
);

    localparam logic [1:0] ST_REQ   = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INSN_W-1:0] hold_q, hold_d;
    logic              req_c;
    logic              send_c;

    // Redirect is evaluated first in every state so it overrides all other events.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        hold_d  = hold_q;
        req_c   = 1'b0;
        send_c  = 1'b0;
        case (state_q)
            ST_REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end else begin
                    req_c = 1'b1;
                    if (imem_req_ready) state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = imem_rsp_valid ? ST_REQ : ST_DRAIN;
                end else if (imem_rsp_valid) begin
                    hold_d  = imem_rsp_data;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = ST_REQ;
                end else if (!f2d_busy) begin
                    send_c  = 1'b1;
                    pc_d    = pc_q + ADDR_W'(4);
                    state_d = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (redirect_valid) pc_d = redirect_pc;
                if (imem_rsp_valid) state_d = ST_REQ;
            end
            default: state_d = ST_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
        end
    end

    // Request valid is gated by reset_n so it drops the instant reset is asserted.
    assign imem_req_valid = req_c & reset_n;
    assign imem_req_addr  = pc_q;
    assign f2d_send       = send_c;
    assign f2d_pc         = send_c ? pc_q   : '0;
    assign f2d_insn       = send_c ? hold_q : '0;

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] fetched_q, stall_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetched_q <= '0;
            stall_q   <= '0;
        end else begin
            if (send_c) fetched_q <= fetched_q + 32'd1;
            if (state_q == ST_SEND && f2d_busy) stall_q <= stall_q + 32'd1;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: random memory/bus/redirect stimulus plus directed scenarios.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h100;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        f2d_busy;
    logic        f2d_send;
    logic [31:0] f2d_pc;
    logic [31:0] f2d_insn;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(32), .INSN_W(32), .RESET_PC(RPC)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .f2d_busy       (f2d_busy),
        .f2d_send       (f2d_send),
        .f2d_pc         (f2d_pc),
        .f2d_insn       (f2d_insn),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef FETCH_PERF_COUNTERS_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Instruction memory contents: fixed word at 0x104, address hash elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h104) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'hA5A50F0F;
    endfunction

    typedef struct packed { logic [31:0] pc; logic [31:0] insn; } pkt_t;
    pkt_t exp_q[$];

    // Stimulus knobs
    int          rdy_pct = 100, busy_pct = 0, redir_pct = 0, dly_max = 0, dly_fixed = -1;
    bit          garbage_en = 1'b0;
    bit          force_redir = 1'b0;
    logic [31:0] force_pc = '0;

    // Memory model state
    bit          out_pending = 1'b0, stale = 1'b0;
    logic [31:0] out_addr = '0;
    int          out_cnt = 0, acc_cnt = 0, rsp_cnt = 0;

    // Monitor state
    int          cyc = 0, sent_cnt = 0, idle = 0;
    logic [31:0] send_pc_log[$];
    int          send_cyc_log[$];
    bit          prev_hold = 1'b0;
    logic [31:0] prev_addr = '0;

    // Driver + memory model: drives inputs just after the rising edge, books acceptances on the falling edge.
    initial begin
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        f2d_busy = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        forever begin
            @(posedge clk); #1;
            imem_req_ready = ($urandom_range(0, 99) < rdy_pct);
            f2d_busy       = ($urandom_range(0, 99) < busy_pct);
            redirect_valid = 1'b0;
            if (reset_n) begin
                if (force_redir) begin
                    redirect_valid = 1'b1; redirect_pc = force_pc; force_redir = 1'b0;
                end else if ($urandom_range(0, 99) < redir_pct) begin
                    redirect_valid = 1'b1; redirect_pc = $urandom & 32'h0000_FFFC;
                end
                if (redirect_valid) begin
                    exp_q.delete();
                    exp_q.push_back(pkt_t'{pc: redirect_pc, insn: mem_word(redirect_pc)});
                end
            end
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
            if (out_pending) begin
                if (out_cnt == 0) begin
                    imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(out_addr);
                end else out_cnt--;
            end else if (garbage_en && $urandom_range(0, 9) == 0) begin
                imem_rsp_valid = 1'b1;
            end
            @(negedge clk);
            if (!reset_n) begin
                if (out_pending) stale = 1'b1;
            end else if (imem_req_valid) begin
                chk("one_outstanding", 32'(out_pending && !stale), 32'd0);
            end
            if (imem_rsp_valid && out_pending) begin
                out_pending = 1'b0; stale = 1'b0; rsp_cnt++;
            end
            if (reset_n && imem_req_valid && imem_req_ready) begin
                out_pending = 1'b1; stale = 1'b0; out_addr = imem_req_addr;
                out_cnt = (dly_fixed >= 0) ? dly_fixed : $urandom_range(0, dly_max);
                acc_cnt++;
            end
        end
    end

    // Monitor: pops the expected packet whenever the DUT sends, and checks request behaviour.
    initial begin
        pkt_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                exp_q.delete();
                exp_q.push_back(pkt_t'{pc: RPC, insn: mem_word(RPC)});
                cyc = 0; sent_cnt = 0; idle = 0; prev_hold = 1'b0;
                send_pc_log.delete(); send_cyc_log.delete();
            end else begin
                cyc++;
`ifdef FETCH_PERF_COUNTERS_EN
                chk("perf_fetched", perf_fetched, 32'(sent_cnt));
`endif
                if (redirect_valid) begin
                    chk("redir_no_req", 32'(imem_req_valid), 32'd0);
                    chk("redir_no_send", 32'(f2d_send), 32'd0);
                    idle = 0;
                end
                if (prev_hold && !redirect_valid) begin
                    chk("req_hold_valid", 32'(imem_req_valid), 32'd1);
                    chk("req_hold_addr", imem_req_addr, prev_addr);
                end
                if (imem_req_valid && exp_q.size() > 0)
                    chk("req_addr", imem_req_addr, exp_q[0].pc);
                if (f2d_send) begin
                    if (exp_q.size() == 0) begin
                        chk("send_unexpected", 32'(f2d_send), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("send_pc", f2d_pc, e.pc);
                        chk("send_insn", f2d_insn, e.insn);
                        exp_q.push_back(pkt_t'{pc: e.pc + 32'd4, insn: mem_word(e.pc + 32'd4)});
                    end
                    sent_cnt++;
                    send_pc_log.push_back(f2d_pc);
                    send_cyc_log.push_back(cyc);
                    idle = 0;
                end else if (!redirect_valid) begin
                    idle++;
                    if (idle > 150) begin
                        chk("progress_timeout", 32'(idle), 32'd150);
                        idle = 0;
                    end
                end
                prev_hold = imem_req_valid && !imem_req_ready;
                prev_addr = imem_req_addr;
            end
        end
    end

    // kind: 0 = sends, 1 = acceptances, 2 = responses
    task automatic wait_evt(input int kind, input int target);
        int cur;
        for (int t = 0; t < 1000; t++) begin
            cur = (kind == 0) ? sent_cnt : (kind == 1) ? acc_cnt : rsp_cnt;
            if (cur >= target) return;
            @(negedge clk); #2;
        end
        chk("wait_timeout", 32'(kind), 32'hFFFF_FFFF);
    endtask

    task automatic wait_req();
        for (int t = 0; t < 200; t++) begin
            if (imem_req_valid) return;
            @(negedge clk); #2;
        end
        chk("wait_req_timeout", 32'(imem_req_valid), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_send", 32'(f2d_send), 32'd0);
        chk("rst_f2d_pc", f2d_pc, 32'd0);
        chk("rst_f2d_insn", f2d_insn, 32'd0);
`ifdef FETCH_PERF_COUNTERS_EN
        chk("rst_perf_fetched", perf_fetched, 32'd0);
        chk("rst_perf_stall", perf_stall, 32'd0);
`endif
        repeat (2) @(negedge clk);
        @(posedge clk); #3;
        reset_n = 1'b1;
        @(negedge clk); #2;
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr", imem_req_addr, RPC);
    endtask

    initial begin
        int r0, a0, s0;
        // Back-to-back fetch latency and sequential PCs
        do_reset();
        wait_evt(0, 3);
        if (send_cyc_log.size() >= 3) begin
            chk("lat_cyc0", 32'(send_cyc_log[0]), 32'd3);
            chk("lat_pc0", send_pc_log[0], 32'h100);
            chk("lat_cyc1", 32'(send_cyc_log[1]), 32'd6);
            chk("lat_pc1", send_pc_log[1], 32'h104);
            chk("lat_cyc2", 32'(send_cyc_log[2]), 32'd9);
            chk("lat_pc2", send_pc_log[2], 32'h108);
        end else chk("lat_sends", 32'(send_cyc_log.size()), 32'd3);

        // Decode bus busy for five cycles while the packet at 0x104 is held
        do_reset();
        wait_evt(0, 1);
        busy_pct = 100;
        wait_evt(2, 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #2;
            chk("busy_no_send", 32'(f2d_send), 32'd0);
        end
        busy_pct = 0;
        @(negedge clk); #2;
        chk("busy_release_send", 32'(f2d_send), 32'd1);
        chk("busy_release_pc", f2d_pc, 32'h104);
        chk("busy_release_insn", f2d_insn, 32'hDEADBEEF);
`ifdef FETCH_PERF_COUNTERS_EN
        chk("perf_stall_5", perf_stall, 32'd5);
`endif

        // Redirect while waiting; response arrives two cycles later and must be drained
        dly_fixed = 2;
        a0 = acc_cnt;
        wait_evt(1, a0 + 1);
        r0 = rsp_cnt;
        force_pc = 32'h2000; force_redir = 1'b1;
        @(negedge clk); #2;
        wait_req();
        chk("drain_req_addr", imem_req_addr, 32'h2000);
        chk("drain_rsp_consumed", 32'(rsp_cnt), 32'(r0 + 1));
        dly_fixed = -1;
        s0 = sent_cnt;
        wait_evt(0, s0 + 1);
        chk("drain_next_pc", send_pc_log[$], 32'h2000);

        // Redirect in the same cycle the packet would be sent
        r0 = rsp_cnt;
        wait_evt(2, r0 + 1);
        force_pc = 32'h40; force_redir = 1'b1;
        @(negedge clk); #2;
        chk("redir_send_suppressed", 32'(f2d_send), 32'd0);
        s0 = sent_cnt;
        wait_evt(0, s0 + 1);
        chk("redir_next_pc", send_pc_log[$], 32'h40);

        // PC wraps past the top of the address space
        force_pc = 32'hFFFF_FFFC; force_redir = 1'b1;
        s0 = sent_cnt;
        wait_evt(0, s0 + 1);
        chk("wrap_send_pc", send_pc_log[$], 32'hFFFF_FFFC);
        wait_req();
        chk("wrap_req_addr", imem_req_addr, 32'h0);

        // Randomized traffic
        rdy_pct = 70; busy_pct = 30; redir_pct = 4; dly_max = 3; garbage_en = 1'b1;
        repeat (3000) @(negedge clk);
        #2;
        rdy_pct = 100; busy_pct = 0; redir_pct = 0; dly_max = 0; garbage_en = 1'b0;

        // Reset during WAIT; the late response must be ignored
        wait_evt(0, sent_cnt + 2);
        dly_fixed = 5;
        a0 = acc_cnt;
        wait_evt(1, a0 + 1);
        rdy_pct = 0;
        r0 = rsp_cnt;
        do_reset();
        wait_evt(2, r0 + 1);
        rdy_pct = 100; dly_fixed = -1;
        wait_evt(0, 1);
        chk("post_reset_pc", send_pc_log[0], RPC);
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
